// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing datapath muxes and write enables.
// Optional macro MC_CTRL_ADDI_EN adds the addi path (ADDIEX/ADDIWB); otherwise opcode 001000 is illegal.
module mc_control_unit #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] OPCODE,
  input  logic           ZERO,
  input  logic           MEM_RDY,
  output logic           IorD,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic           PCEn,
  output logic           ILLEGAL,
  output logic [STW-1:0] STATE
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_RTYP = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
`ifdef MC_CTRL_ADDI_EN
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
`endif

  state_t state_q, state_d;

  logic       iord_c, memwrite_c, irwrite_c, regdst_c, memtoreg_c, regwrite_c;
  logic       alusrca_c, pcwrite_c, branch_c, illegal_c;
  logic [1:0] alusrcb_c, aluop_c, pcsrc_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    iord_c     = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    aluop_c    = 2'b00;
    pcsrc_c    = 2'b00;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    illegal_c  = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb_c = 2'b01;
        irwrite_c = MEM_RDY;
        pcwrite_c = MEM_RDY;
        if (MEM_RDY) state_d = DECODE;
      end
      DECODE: begin
        alusrcb_c = 2'b11;
        case (OPCODE)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = ADDIEX;
`endif
          default: begin
            illegal_c = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = (OPCODE == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord_c = 1'b1;
        if (MEM_RDY) state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
      // Write strobe stays up until the memory accepts it, giving one accepted write per sw.
      MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
        if (MEM_RDY) state_d = FETCH;
      end
      EXEC: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b01;
        pcsrc_c   = 2'b01;
        branch_c  = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pcsrc_c   = 2'b10;
        pcwrite_c = 1'b1;
        state_d   = FETCH;
      end
`ifdef MC_CTRL_ADDI_EN
      ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  // Everything is held at zero while reset is asserted, even though FETCH is already active.
  assign IorD     = ~RST & iord_c;
  assign MemWrite = ~RST & memwrite_c;
  assign IRWrite  = ~RST & irwrite_c;
  assign RegDst   = ~RST & regdst_c;
  assign MemtoReg = ~RST & memtoreg_c;
  assign RegWrite = ~RST & regwrite_c;
  assign ALUSrcA  = ~RST & alusrca_c;
  assign ALUSrcB  = RST ? 2'b00 : alusrcb_c;
  assign ALUOp    = RST ? 2'b00 : aluop_c;
  assign PCSrc    = RST ? 2'b00 : pcsrc_c;
  assign PCEn     = ~RST & (pcwrite_c | (branch_c & ZERO));
  assign ILLEGAL  = ~RST & illegal_c;
  assign STATE    = STW'(state_q);

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed scenarios plus random instruction streams
// checked against a per-instruction expected state/handshake sequence and a control table.
module tb_mc_control_unit;
  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] OPCODE;
  logic       ZERO, MEM_RDY;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, ILLEGAL;
  logic [3:0] STATE;

  int checks = 0;
  int failures = 0;

  logic [3:0] exp_q[$];
  logic       rdy_q[$];

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  mc_control_unit dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .ZERO(ZERO), .MEM_RDY(MEM_RDY),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .ILLEGAL(ILLEGAL), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  function automatic bit addi_en();
`ifdef MC_CTRL_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    if (op == LW || op == SW || op == RT || op == BEQ || op == JMP) return 1'b1;
    if (op == ADDI) return addi_en();
    return 1'b0;
  endfunction

  // Expected control word {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCEn,ILLEGAL}
  function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                           input logic z, input logic [5:0] op);
    logic iord, mw, irw, rd, m2r, rw, sa, pcen, ill;
    logic [1:0] sb, aop, pcs;
    {iord, mw, irw, rd, m2r, rw, sa, pcen, ill} = '0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      4'd0:  begin sb = 2'b01; irw = rdy; pcen = rdy; end
      4'd1:  begin sb = 2'b11; ill = !is_legal(op); end
      4'd2:  begin sa = 1'b1; sb = 2'b10; end
      4'd3:  iord = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin iord = 1'b1; mw = 1'b1; end
      4'd6:  begin sa = 1'b1; aop = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin sa = 1'b1; aop = 2'b01; pcs = 2'b01; pcen = z; end
      4'd9:  begin pcs = 2'b10; pcen = 1'b1; end
      4'd10: begin sa = 1'b1; sb = 2'b10; end
      4'd11: rw = 1'b1;
      default: ;
    endcase
    return {iord, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, pcen, ill};
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle (state, MEM_RDY) pairs for one instruction starting in FETCH.
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) begin exp_q.push_back(4'd0); rdy_q.push_back(1'b0); end
    exp_q.push_back(4'd0); rdy_q.push_back(1'b1);
    exp_q.push_back(4'd1); rdy_q.push_back(rnd_bit());
    if (!is_legal(op)) return;
    if (op == LW || op == SW) begin
      logic [3:0] acc;
      acc = (op == LW) ? 4'd3 : 4'd5;
      exp_q.push_back(4'd2); rdy_q.push_back(rnd_bit());
      for (int i = 0; i < mw; i++) begin exp_q.push_back(acc); rdy_q.push_back(1'b0); end
      exp_q.push_back(acc); rdy_q.push_back(1'b1);
      if (op == LW) begin exp_q.push_back(4'd4); rdy_q.push_back(rnd_bit()); end
    end else if (op == RT) begin
      exp_q.push_back(4'd6); rdy_q.push_back(rnd_bit());
      exp_q.push_back(4'd7); rdy_q.push_back(rnd_bit());
    end else if (op == BEQ) begin
      exp_q.push_back(4'd8); rdy_q.push_back(rnd_bit());
    end else if (op == JMP) begin
      exp_q.push_back(4'd9); rdy_q.push_back(rnd_bit());
    end else begin
      exp_q.push_back(4'd10); rdy_q.push_back(rnd_bit());
      exp_q.push_back(4'd11); rdy_q.push_back(rnd_bit());
    end
  endtask

  // Drains the expected queues one clock at a time; inputs change 1 time unit after posedge.
  task automatic run_seq(input string name);
    logic [3:0]  st;
    logic        rdy;
    logic [14:0] exp_c, act_c;
    while (exp_q.size() > 0) begin
      st  = exp_q.pop_front();
      rdy = rdy_q.pop_front();
      MEM_RDY = rdy;
      @(negedge CLK);
      checks++;
      if (STATE !== st) begin
        failures++;
        $display("FAIL %s state: got %0d expected %0d", name, STATE, st);
      end
      exp_c = exp_ctrl(st, rdy, ZERO, OPCODE);
      act_c = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSrc, PCEn, ILLEGAL};
      checks++;
      if (act_c !== exp_c) begin
        failures++;
        $display("FAIL %s ctrl in state %0d: got %h expected %h", name, st, act_c, exp_c);
      end
      checks++;
      if (RegWrite === 1'b1 && MemWrite === 1'b1) begin
        failures++;
        $display("FAIL %s exclusive_write: got RegWrite=1 MemWrite=1 expected not both", name);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input logic z, input string name);
    OPCODE = op;
    ZERO   = z;
    build(op, fw, mw);
    run_seq(name);
  endtask

  task automatic test_reset();
    RST = 1'b1; MEM_RDY = 1'b1; OPCODE = LW; ZERO = 1'b1;
    @(negedge CLK);
    checks++;
    if (STATE !== 4'd0 || IRWrite !== 1'b0 || PCEn !== 1'b0 || ALUSrcB !== 2'b00 || ILLEGAL !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got st=%0d irw=%b pcen=%b srcb=%b ill=%b expected 0 0 0 00 0",
               STATE, IRWrite, PCEn, ALUSrcB, ILLEGAL);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_lw();      run_instr(LW, 0, 0, rnd_bit(), "lw"); endtask
  task automatic test_sw_wait(); run_instr(SW, 0, 3, rnd_bit(), "sw_wait"); endtask

  task automatic test_beq();
    run_instr(BEQ, 0, 0, 1'b1, "beq_taken");
    run_instr(BEQ, 0, 0, 1'b0, "beq_not_taken");
  endtask

  task automatic test_back_to_back();
    run_instr(RT, 0, 0, rnd_bit(), "rtype");
    run_instr(JMP, 0, 0, rnd_bit(), "jump");
    run_instr(LW, 2, 1, rnd_bit(), "lw_waits");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 0, 0, rnd_bit(), "illegal_3f");
    run_instr(ADDI, 0, 0, rnd_bit(), "addi");
    run_instr(LW, 0, 0, rnd_bit(), "after_addi");
  endtask

  task automatic test_reset_mid_sw();
    OPCODE = SW; ZERO = 1'b0;
    exp_q.push_back(4'd0); rdy_q.push_back(1'b1);
    exp_q.push_back(4'd1); rdy_q.push_back(1'b0);
    exp_q.push_back(4'd2); rdy_q.push_back(1'b0);
    run_seq("pre_reset_sw");
    MEM_RDY = 1'b0;
    #1;
    checks++;
    if (STATE !== 4'd5 || MemWrite !== 1'b1) begin
      failures++;
      $display("FAIL memwr_entry: got st=%0d mw=%b expected 5 1", STATE, MemWrite);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (STATE !== 4'd0 || MemWrite !== 1'b0 || IorD !== 1'b0 || ALUSrcB !== 2'b00) begin
      failures++;
      $display("FAIL async_reset: got st=%0d mw=%b iord=%b srcb=%b expected 0 0 0 00",
               STATE, MemWrite, IorD, ALUSrcB);
    end
    MEM_RDY = 1'b1;
    @(negedge CLK);
    checks++;
    if (IRWrite !== 1'b0 || PCEn !== 1'b0 || RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL reset_enables: got irw=%b pcen=%b rw=%b expected 0 0 0", IRWrite, PCEn, RegWrite);
    end
    @(posedge CLK); #2;
    RST = 1'b0; MEM_RDY = 1'b0;
    @(negedge CLK);
    checks++;
    if (STATE !== 4'd0 || IorD !== 1'b0 || ALUSrcB !== 2'b01 || IRWrite !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_fetch: got st=%0d iord=%b srcb=%b irw=%b expected 0 0 01 0",
               STATE, IorD, ALUSrcB, IRWrite);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_random();
    logic [5:0] ops[6];
    logic [5:0] op;
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ; ops[4] = JMP; ops[5] = ADDI;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      else op = ops[$urandom_range(0, 5)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rnd_bit(), "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_mid_sw();
    test_lw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle MIPS main controller for the shared-memory datapath.
- Sequences the existing 2:1/3:1 datapath muxes (IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc) and the write enables for IR, PC, register file and memory, one instruction over 3-5 states.
- Sits beside the datapath and consumes the IR opcode field.
- ALU function decode remains in the separate ALU decoder, driven by ALUOp.

Parameters:
- OPW, 6, opcode width.
- STW, 4, state register width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- OPCODE  in  OPW  IR[31:26].
- ZERO  in  1  ALU zero flag.
- MEM_RDY  in  1  memory handshake; access completes in the cycle it is 1.
- IorD  out  1  memory address mux select (0=PC, 1=ALUOut).
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write-register mux select (0=rt, 1=rd).
- MemtoReg  out  1  write-data mux select (0=ALUOut, 1=MDR).
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A mux select (0=PC, 1=A).
- ALUSrcB  out  2  ALU B mux select (00=B, 01=4, 10=SignImm, 11=SignImm<<2).
- ALUOp  out  2  to ALU decoder (00=add, 01=sub, 10=funct).
- PCSrc  out  2  PC mux select (00=ALUResult, 01=ALUOut, 10=jump target).
- PCEn  out  1  PC load = PCWrite | (Branch & ZERO).
- ILLEGAL  out  1  one-cycle pulse on unknown opcode.
- STATE  out  STW  current state, for debug.

Behaviour:
- Single Moore FSM, state register on posedge CLK, async clear on RST.
- Reset:
  - State = FETCH(0).
  - While RST=1, all enables (MemWrite, IRWrite, RegWrite, PCEn) and ILLEGAL are forced 0; selects are 0.
  - Reset mid-instruction abandons it; no partial writes after RST asserts.
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- FETCH:
  - Outputs: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite = MEM_RDY.
  - Stay while MEM_RDY=0; go to DECODE when MEM_RDY=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by OPCODE: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX (feature-gated).
  - Any other opcode -> FETCH with ILLEGAL=1 for this cycle.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - lw -> MEMRD, sw -> MEMWR (OPCODE held stable by IR).
- MEMRD: IorD=1. Wait for MEM_RDY, then -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR:
  - IorD=1, MemWrite=1, held until MEM_RDY=1, then -> FETCH.
  - Exactly one accepted write per sw.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - PCEn=ZERO. -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- Any unused state encoding -> FETCH next cycle with all enables 0.
- Latency with MEM_RDY tied 1, in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Only one enable group per state; RegWrite and MemWrite are never both 1.

Optional Feature:
- Macro MC_CTRL_ADDI_EN.
- Defined: opcode 001000 decodes to ADDIEX/ADDIWB as above.
- Undefined: ADDIEX/ADDIWB are not built; 001000 is treated as illegal (ILLEGAL pulse, return to FETCH).

Test Plan:
- Reset: assert RST asynchronously mid-cycle in MEMWR -> STATE=0 immediately, MemWrite=0; after release, FETCH with IorD=0, ALUSrcB=01.
- lw (100011), MEM_RDY=1 -> STATE sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with MemtoReg=1, RegDst=0.
- sw (101011) with MEM_RDY low for 3 cycles in MEMWR -> MemWrite high 4 cycles, STATE stays 5, then returns to 0; RegWrite never 1.
- beq (000100): ZERO=1 -> PCEn=1, PCSrc=01 in state 8. ZERO=0 -> PCEn=0. Both cases return to FETCH.
- R-type (000000) then j (000010) -> states 0,1,6,7,0,1,9,0; ALUOp=10 in state 6; PCSrc=10 and PCEn=1 in state 9.
- Opcode 111111 -> ILLEGAL pulses 1 cycle in DECODE, next STATE=0. Repeat with 001000: builds without MC_CTRL_ADDI_EN -> ILLEGAL; builds with it -> states 10, 11, RegWrite=1, RegDst=0.
